// File: rtl/div32_seq.sv
// Iterative 32-bit restoring divider (DIV/DIVU), LO=q, HI=r, one quotient bit per cycle.
// Latency: start sampled at edge 0 -> done in cycle 34 (cycle 1 when the divisor is zero).
// Backpressure: none; busy stalls the pipeline, start while busy/done is dropped, cancel aborts.
//
// Ports:
//   clk, rst_n       clock (rising edge), asynchronous active-low reset
//   start            start request, sampled in IDLE only
//   sign             1 = signed (DIV), 0 = unsigned (DIVU); latched at start
//   a, b             dividend / divisor; latched at start
//   cancel           pipeline flush; aborts a running operation (CALC/FIXUP)
//   busy             high while in CALC or FIXUP
//   done             one-cycle pulse; q/r/dbz valid
//   q, r             quotient / remainder, held until the next completed operation
//   dbz              divide-by-zero flag of the last completed operation
//
// Configuration macro: DIV_SIGNED_EN. When undefined the sign input is ignored and
// every operation is unsigned; the FIXUP cycle still exists so latency is unchanged.

module addsub32 (
  input  logic [31:0] a,
  input  logic [31:0] b,
  input  logic        sub,
  output logic [31:0] y,
  output logic        cout
);
  // Subtraction as a + ~b + 1; cout=1 on subtract means "no borrow".
  logic [32:0] sum;

  assign sum  = {1'b0, a} + {1'b0, (sub ? ~b : b)} + {32'd0, sub};
  assign y    = sum[31:0];
  assign cout = sum[32];
endmodule

module div32_seq #(
  parameter int WIDTH = 32,
  parameter int CNT_W = 5
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             sign,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cancel,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] q,
  output logic [WIDTH-1:0] r,
  output logic             dbz
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    CALC  = 2'd1,
    FIXUP = 2'd2,
    DONE  = 2'd3
  } state_t;

  state_t           state;
  logic [CNT_W-1:0] cnt;
  logic [WIDTH-1:0] rem;     // partial remainder
  logic [WIDTH-1:0] dvd;     // dividend magnitude, shifted out MSB first
  logic [WIDTH-1:0] div;     // divisor magnitude
  logic [WIDTH-1:0] quo;     // quotient being assembled
  logic             neg_q;
  logic             neg_r;

  // Effective signedness of the request presented this cycle.
  logic eff_sign;
`ifdef DIV_SIGNED_EN
  assign eff_sign = sign;
`else
  logic unused_sign;
  assign eff_sign    = 1'b0;
  assign unused_sign = sign;
`endif

  logic [WIDTH-1:0] abs_a;
  logic [WIDTH-1:0] abs_b;

  assign abs_a = (eff_sign && a[WIDTH-1]) ? ({WIDTH{1'b0}} - a) : a;
  assign abs_b = (eff_sign && b[WIDTH-1]) ? ({WIDTH{1'b0}} - b) : b;

  // Shared adder: trial subtraction in CALC, quotient negation in FIXUP.
  // The trial value {rem,dvd[31]} is 33 bits; its low 32 bits go through the
  // adder and rem[31] stands in for the 33rd bit. If rem[31] is set the trial
  // value exceeds any divisor, so the subtraction always succeeds and the
  // 32-bit difference is exact (the result is below the divisor).
  logic [WIDTH-1:0] as_a;
  logic [WIDTH-1:0] as_b;
  logic [WIDTH-1:0] as_y;
  logic             as_cout;
  logic             qbit;

  always_comb begin
    as_a = {rem[WIDTH-2:0], dvd[WIDTH-1]};
    as_b = div;
    if (state == FIXUP) begin
      as_a = {WIDTH{1'b0}};
      as_b = quo;
    end
  end

  addsub32 u_as_main (
    .a    (as_a),
    .b    (as_b),
    .sub  (1'b1),
    .y    (as_y),
    .cout (as_cout)
  );

  assign qbit = rem[WIDTH-1] | as_cout;

  // The remainder negation must happen in the same FIXUP cycle as the
  // quotient negation, so it gets its own adder.
  logic [WIDTH-1:0] rneg;
  logic             unused_rneg_cout;

  addsub32 u_as_rneg (
    .a    ({WIDTH{1'b0}}),
    .b    (rem),
    .sub  (1'b1),
    .y    (rneg),
    .cout (unused_rneg_cout)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      cnt   <= '0;
      rem   <= '0;
      dvd   <= '0;
      div   <= '0;
      quo   <= '0;
      neg_q <= 1'b0;
      neg_r <= 1'b0;
      busy  <= 1'b0;
      done  <= 1'b0;
      q     <= '0;
      r     <= '0;
      dbz   <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          // cancel is deliberately not looked at here: start always wins.
          if (start) begin
            dbz   <= 1'b0;
            cnt   <= '0;
            rem   <= '0;
            quo   <= '0;
            dvd   <= abs_a;
            div   <= abs_b;
            neg_q <= eff_sign & (a[WIDTH-1] ^ b[WIDTH-1]);
            neg_r <= eff_sign & a[WIDTH-1];
            if (b == '0) begin
              // Divide by zero completes immediately, busy never rises.
              q     <= {WIDTH{1'b1}};
              r     <= a;
              dbz   <= 1'b1;
              done  <= 1'b1;
              state <= DONE;
            end else begin
              busy  <= 1'b1;
              state <= CALC;
            end
          end
        end

        CALC: begin
          if (cancel) begin
            busy  <= 1'b0;
            state <= IDLE;
          end else begin
            rem <= qbit ? as_y : {rem[WIDTH-2:0], dvd[WIDTH-1]};
            quo <= {quo[WIDTH-2:0], qbit};
            dvd <= {dvd[WIDTH-2:0], 1'b0};
            cnt <= cnt + 1'b1;
            if (cnt == CNT_W'(WIDTH - 1)) begin
              state <= FIXUP;
            end
          end
        end

        FIXUP: begin
          if (cancel) begin
            busy  <= 1'b0;
            state <= IDLE;
          end else begin
            // Outputs change only here and on divide-by-zero, so partial
            // results never reach q/r.
            q     <= neg_q ? as_y : quo;
            r     <= neg_r ? rneg : rem;
            busy  <= 1'b0;
            done  <= 1'b1;
            state <= DONE;
          end
        end

        default: begin
          // DONE: start and cancel are both ignored for this one cycle.
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_div32_seq.sv
module tb_div32_seq;

  logic        clk;
  logic        rst_n;
  logic        start;
  logic        sign;
  logic [31:0] a;
  logic [31:0] b;
  logic        cancel;
  logic        busy;
  logic        done;
  logic [31:0] q;
  logic [31:0] r;
  logic        dbz;

  div32_seq dut (
    .clk    (clk),
    .rst_n  (rst_n),
    .start  (start),
    .sign   (sign),
    .a      (a),
    .b      (b),
    .cancel (cancel),
    .busy   (busy),
    .done   (done),
    .q      (q),
    .r      (r),
    .dbz    (dbz)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] q;
    logic [31:0] r;
    logic        dbz;
    int          lat;
  } exp_t;

  exp_t        sb[$];
  int          n_chk  = 0;
  int          n_fail = 0;
  logic [31:0] last_q = 32'd0;
  logic [31:0] last_r = 32'd0;
  logic        last_dbz = 1'b0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  // Reference result from the language's own / and % on magnitudes.
  function automatic exp_t model(input logic [31:0] ma, input logic [31:0] mb, input logic ms);
    exp_t        e;
    logic        sg;
    logic [31:0] ua;
    logic [31:0] ub;
`ifdef DIV_SIGNED_EN
    sg = ms;
`else
    sg = ms & 1'b0;
`endif
    if (mb == 32'd0) begin
      e.q = 32'hFFFFFFFF; e.r = ma; e.dbz = 1'b1; e.lat = 1;
      return e;
    end
    ua = (sg && ma[31]) ? (32'd0 - ma) : ma;
    ub = (sg && mb[31]) ? (32'd0 - mb) : mb;
    e.q = ua / ub;
    e.r = ua % ub;
    if (sg && (ma[31] ^ mb[31])) e.q = 32'd0 - e.q;
    if (sg && ma[31])            e.r = 32'd0 - e.r;
    e.dbz = 1'b0;
    e.lat = 34;
    return e;
  endfunction

  // Drive a start for one cycle; returns in cycle 1 of the operation.
  task automatic launch(input logic [31:0] ta, input logic [31:0] tb_, input logic ts, input logic tc);
    @(negedge clk);
    start = 1'b1; a = ta; b = tb_; sign = ts; cancel = tc;
    sb.push_back(model(ta, tb_, ts));
    @(negedge clk);
    start = 1'b0; cancel = 1'b0;
  endtask

  // Run to done, optionally pulsing a stray start at cycle inj_cyc and/or in
  // the DONE cycle, then compare against the scoreboard head.
  task automatic finish_op(input int inj_cyc, input bit poke_done);
    int   cyc;
    int   nbusy;
    exp_t e;
    cyc   = 1;
    nbusy = 0;
    e     = sb[0];
    while (done !== 1'b1 && cyc < 60) begin
      if (busy === 1'b1) nbusy++;
      if (cyc == 1 && !e.dbz) check("dbz_clear", {31'd0, dbz}, 32'd0);
      if (cyc == inj_cyc) begin
        start = 1'b1; a = 32'hDEAD0000; b = 32'd0;
      end
      @(negedge clk);
      start = 1'b0;
      cyc++;
    end
    if (done !== 1'b1) begin
      check("done_timeout", 32'd0, 32'd1);
      void'(sb.pop_front());
      return;
    end
    e = sb.pop_front();
    check("q", q, e.q);
    check("r", r, e.r);
    check("dbz", {31'd0, dbz}, {31'd0, e.dbz});
    check("latency", 32'(cyc), 32'(e.lat));
    check("busy_at_done", {31'd0, busy}, 32'd0);
    check("busy_cycles", 32'(nbusy), e.dbz ? 32'd0 : 32'd33);
    last_q = e.q; last_r = e.r; last_dbz = e.dbz;
    if (poke_done) begin
      start = 1'b1; a = 32'h5555AAAA; b = 32'd0;
      @(negedge clk);
      start = 1'b0;
      check("done_start_ignored", {30'd0, busy, done}, 32'd0);
      check("q_hold", q, last_q);
    end
  endtask

  task automatic do_div(input logic [31:0] ta, input logic [31:0] tb_, input logic ts);
    launch(ta, tb_, ts, 1'b0);
    finish_op(0, 1'b0);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    int ndone;
    rst_n = 1'b0; start = 1'b0; sign = 1'b0; a = '0; b = '0; cancel = 1'b0;
    #12;
    check("rst_busy", {31'd0, busy}, 32'd0);
    check("rst_done", {31'd0, done}, 32'd0);
    check("rst_q", q, 32'd0);
    check("rst_r", r, 32'd0);
    check("rst_dbz", {31'd0, dbz}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;

    // Directed cases
    launch(32'd100, 32'd7, 1'b0, 1'b0);   finish_op(0, 1'b1);
    do_div(32'hFFFFFFF9, 32'd2, 1'b1);
    do_div(32'h00001234, 32'd0, 1'b0);    // divide by zero
    do_div(32'd100, 32'd7, 1'b0);         // clears dbz at start
    do_div(32'h80000000, 32'hFFFFFFFF, 1'b1);
    do_div(32'd0, 32'd5, 1'b0);
    do_div(32'd5, 32'd7, 1'b0);
    do_div(32'hFFFFFFFF, 32'd1, 1'b0);
    do_div(32'hFFFFFFFF, 32'hFFFFFFFF, 1'b0);
    do_div(32'd7, 32'hFFFFFFFE, 1'b1);
    do_div(32'hFFFFFFF8, 32'hFFFFFFFD, 1'b1);

    // start and cancel together in IDLE: start wins
    launch(32'd1000, 32'd33, 1'b0, 1'b1); finish_op(0, 1'b0);

    // Random operands
    for (int i = 0; i < 8; i++) begin
      logic [31:0] ra;
      logic [31:0] rb;
      ra = $urandom;
      rb = ($urandom_range(0, 1) == 1) ? $urandom : $urandom_range(1, 300);
      do_div(ra, rb, 1'($urandom_range(0, 1)));
    end

    // Cancel at cycle 10: back to IDLE at cycle 11, no done, outputs held
    do_div(32'd12345, 32'd67, 1'b0);
    launch(32'd5000, 32'd3, 1'b0, 1'b0);
    for (int i = 1; i < 10; i++) @(negedge clk);
    cancel = 1'b1;
    @(negedge clk);
    cancel = 1'b0;
    check("cancel_idle", {31'd0, busy}, 32'd0);
    void'(sb.pop_back());
    ndone = 0;
    repeat (40) begin
      if (done === 1'b1 || busy === 1'b1) ndone++;
      @(negedge clk);
    end
    check("cancel_quiet", 32'(ndone), 32'd0);
    check("cancel_q_hold", q, last_q);
    check("cancel_r_hold", r, last_r);
    check("cancel_dbz_hold", {31'd0, dbz}, {31'd0, last_dbz});
    do_div(32'd999, 32'd10, 1'b0);

    // Stray start at cycle 5 of a running op is ignored
    launch(32'd77777, 32'd13, 1'b0, 1'b0); finish_op(5, 1'b0);

    // Reset at cycle 20 of a running op
    launch(32'd4242, 32'd5, 1'b0, 1'b0);
    for (int i = 1; i < 20; i++) @(negedge clk);
    rst_n = 1'b0;
    #1;
    check("midrst_busy", {31'd0, busy}, 32'd0);
    check("midrst_done", {31'd0, done}, 32'd0);
    check("midrst_q", q, 32'd0);
    check("midrst_r", r, 32'd0);
    check("midrst_dbz", {31'd0, dbz}, 32'd0);
    void'(sb.pop_back());
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    ndone = 0;
    repeat (40) begin
      if (done === 1'b1 || busy === 1'b1) ndone++;
      @(negedge clk);
    end
    check("postrst_quiet", 32'(ndone), 32'd0);
    do_div(32'd81, 32'd9, 1'b0);

    check("sb_empty", 32'(sb.size()), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
